reduce_channel_arbiter: RTL

Shares one pipelined reduce channel (structure_reduce_channel_pipelined_adds: 1-cycle latency, result = in_data+2 when valid, 0 otherwise) among NUM_REQ requesters. Each cycle a round-robin arbiter picks at most one request and drives it into the channel. A tag pipeline tracks the owner of each in-flight operation, and the block returns each result to that owner as a one-hot response. The block sits between the requester-side logic and the channel instance; the channel instance itself stays outside this block.

---
 rtl/reduce_channel_arbiter_pkg.sv | 34 +++
 rtl/reduce_channel_arbiter_rr.sv | 68 ++++++
 rtl/reduce_channel_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/reduce_channel_arbiter_pkg.sv
// Shared definitions for the reduce-channel arbiter: default sizes, tag
// format and small index helpers used by the arbiter and the top level.
package reduce_channel_arbiter_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_LATENCY = 1;
    localparam int TAG_W       = 3;
    localparam int MAX_REQ     = 8;

    // One tag-pipeline stage: owner of the operation at this depth.
    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] id;
    } tag_t;

    // Next round-robin position after idx, wrapping explicitly at n-1 so
    // the pointer never holds a value >= n (n need not be a power of two).
    function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] idx,
                                                  input int               n);
        logic [TAG_W-1:0] nxt;
        if (int'(idx) >= (n - 1)) begin
            nxt = {TAG_W{1'b0}};
        end else begin
            nxt = idx + {{(TAG_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // True when the tag is live and belongs to requester i (one-hot decode bit).
    function automatic logic idx_hit(input tag_t t, input int i);
        return t.vld && (t.id == TAG_W'(i));
    endfunction

endpackage

// File: rtl/reduce_channel_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping to the low indices, and moves the pointer past each winner.
module rr_arbiter
    import reduce_channel_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [TAG_W-1:0]   grant_idx
);

    logic [TAG_W-1:0]   ptr_q;
    logic [TAG_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] grant_s;
    logic [TAG_W-1:0]   idx_s;
    logic               found_s;

    // Two-pass priority search: indices >= ptr first, then the wrapped ones below ptr.
    always_comb begin
        grant_s = {NUM_REQ{1'b0}};
        idx_s   = {TAG_W{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_s && req[i] && (i >= int'(ptr_q))) begin
                found_s    = 1'b1;
                grant_s[i] = 1'b1;
                idx_s      = TAG_W'(i);
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_s && req[i] && (i < int'(ptr_q))) begin
                found_s    = 1'b1;
                grant_s[i] = 1'b1;
                idx_s      = TAG_W'(i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer moves just past the winner on a transfer, otherwise holds.
    always_comb begin
        if (advance) begin
            ptr_d = wrap_inc(idx_s, NUM_REQ);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= {TAG_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant     = grant_s;
    assign grant_idx = idx_s;

endmodule

// File: rtl/reduce_channel_arbiter.sv
// Shares one pipelined reduce channel among NUM_REQ requesters. A round-robin
// arbiter feeds the channel, a tag pipeline remembers who owns each in-flight
// operation, and the result is returned to that owner as a one-hot response.
module reduce_channel_arbiter
    import reduce_channel_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_en,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     ch_in_valid,
    output logic [WIDTH-1:0]         ch_in_data,
    input  logic [WIDTH-1:0]         ch_result,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_data,
    output logic [2:0]               in_flight
);

    logic [NUM_REQ-1:0] cand_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [TAG_W-1:0]   grant_idx_s;
    logic               issue_s;
    logic [WIDTH-1:0]   ch_in_data_s;

    tag_t               tag_q [LATENCY];
    tag_t               tag_d [LATENCY];
    tag_t               last_s;

    logic [NUM_REQ-1:0] resp_valid_q;
    logic [NUM_REQ-1:0] resp_valid_d;
    logic [WIDTH-1:0]   resp_data_q;
    logic [WIDTH-1:0]   resp_data_d;
    logic [2:0]         in_flight_q;
    logic [2:0]         in_flight_d;

    // Pausing masks every request before arbitration, so grants stop at once.
    assign cand_s = req_valid & {NUM_REQ{issue_en}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (cand_s),
        .advance   (issue_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign issue_s = |grant_s;

    // AND-OR mux of the granted requester's data; zero when nobody is granted.
    always_comb begin
        ch_in_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            ch_in_data_s = ch_in_data_s | (req_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
        end
    end

    // Tag pipeline next state: new owner enters stage 0, older tags shift down.
    always_comb begin
        for (int k = 0; k < LATENCY; k++) begin
            tag_d[k] = '0;
        end
        tag_d[0].vld = issue_s;
        tag_d[0].id  = grant_idx_s;
        for (int k = 1; k < LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    assign last_s = tag_q[LATENCY-1];

    // Response next state: the last tag lines up with ch_result this cycle.
    always_comb begin
        resp_valid_d = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid_d[i] = idx_hit(last_s, i);
        end
        if (last_s.vld) begin
            resp_data_d = ch_result;
        end else begin
            resp_data_d = {WIDTH{1'b0}};
        end
    end

    // Occupancy: +1 for an issue, -1 for the response leaving; both net to zero.
    always_comb begin
        in_flight_d = in_flight_q + {2'b00, issue_s} - {2'b00, (|resp_valid_q)};
    end

    // Tag pipeline, response and occupancy registers; reset drops every in-flight tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            resp_valid_q <= {NUM_REQ{1'b0}};
            resp_data_q  <= {WIDTH{1'b0}};
            in_flight_q  <= 3'd0;
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= tag_d[k];
            end
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            in_flight_q  <= in_flight_d;
        end
    end

    assign req_ready   = grant_s;
    assign ch_in_valid = issue_s;
    assign ch_in_data  = ch_in_data_s;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign in_flight   = in_flight_q;

endmodule
